// File: rtl/mood_stimulus_controller.sv
// rtl/mood_stimulus_controller.sv - stimulus-to-pulse burst controller for the stress/pleasure mood counters
//
// Purpose:
//   Turns rising edges on the pet/noise stimulus levels into bounded bursts of
//   inc/dec pulses for the stress and pleasure saturating counters, follows each
//   burst with a refractory hold, and applies a periodic passive drift toward
//   mid-range while idle. The counters' 2-bit range indicators steer the drift.
//
// Optional build macro:
//   MOOD_EVENT_QUEUE_EN - adds a one-deep pending-event slot that captures an
//   event arriving while busy and starts its burst directly out of REFRACT.
//
// Ports:
//   clk                 in   clock
//   rst                 in   synchronous reset, active-high
//   stim_pet            in   pet stimulus level
//   stim_noise          in   noise stimulus level
//   asleep              in   sleep state from sleep_controller
//   fell_asleep         in   one-cycle pulse from sleep_controller
//   stress_indicator    in   [1:0] stress range class (0 low .. 3 high)
//   pleasure_indicator  in   [1:0] pleasure range class
//   stress_inc          out  stress counter increment pulse (registered)
//   stress_dec          out  stress counter decrement pulse (registered)
//   pleasure_inc        out  pleasure counter increment pulse (registered)
//   pleasure_dec        out  pleasure counter decrement pulse (registered)
//   busy                out  high whenever state is not IDLE
//   state               out  [1:0] 0 IDLE, 1 PET_BURST, 2 NOISE_BURST, 3 REFRACT

module mood_stimulus_controller #(
  parameter int BURST_LEN    = 4,
  parameter int REFRACTORY   = 8,
  parameter int DECAY_PERIOD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stim_pet,
  input  logic       stim_noise,
  input  logic       asleep,
  input  logic       fell_asleep,
  input  logic [1:0] stress_indicator,
  input  logic [1:0] pleasure_indicator,
  output logic       stress_inc,
  output logic       stress_dec,
  output logic       pleasure_inc,
  output logic       pleasure_dec,
  output logic       busy,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_PET_BURST   = 2'd1,
    ST_NOISE_BURST = 2'd2,
    ST_REFRACT     = 2'd3
  } state_t;

  localparam logic [3:0] BURST_LAST = 4'(BURST_LEN);
  localparam logic [7:0] REFR_LAST  = 8'(REFRACTORY - 1);
  localparam logic [7:0] DECAY_LAST = 8'(DECAY_PERIOD - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic       r_prev_pet;
  logic       r_prev_noise;
  logic [3:0] r_burst_cnt;
  logic [3:0] w_burst_cnt_next;
  logic [7:0] r_refr_cnt;
  logic [7:0] w_refr_cnt_next;
  logic [7:0] r_decay_cnt;
  logic [7:0] w_decay_cnt_next;

  logic       r_stress_inc;
  logic       r_stress_dec;
  logic       r_pleasure_inc;
  logic       r_pleasure_dec;
  logic       w_stress_inc_next;
  logic       w_stress_dec_next;
  logic       w_pleasure_inc_next;
  logic       w_pleasure_dec_next;

  logic       w_ev_pet;
  logic       w_ev_noise;
  logic       w_start_pet;
  logic       w_start_noise;

  assign w_ev_pet   = stim_pet & ~r_prev_pet;
  assign w_ev_noise = stim_noise & ~r_prev_noise;

`ifdef MOOD_EVENT_QUEUE_EN
  logic r_pend_valid;
  logic r_pend_noise;
  logic w_pend_valid_next;
  logic w_pend_noise_next;
  logic w_cap_valid;
  logic w_cap_noise;

  // Pending slot merged with this cycle's events: the first event is kept,
  // a noise event replaces a pending pet, anything else is dropped.
  assign w_cap_valid = r_pend_valid | w_ev_noise | w_ev_pet;
  assign w_cap_noise = w_ev_noise | (r_pend_valid & r_pend_noise);
`endif

  always_comb begin
    w_state_next        = r_state;
    w_burst_cnt_next    = r_burst_cnt;
    w_refr_cnt_next     = r_refr_cnt;
    w_decay_cnt_next    = 8'd0;
    w_stress_inc_next   = 1'b0;
    w_stress_dec_next   = 1'b0;
    w_pleasure_inc_next = 1'b0;
    w_pleasure_dec_next = 1'b0;
    w_start_pet         = 1'b0;
    w_start_noise       = 1'b0;
`ifdef MOOD_EVENT_QUEUE_EN
    w_pend_valid_next   = r_pend_valid;
    w_pend_noise_next   = r_pend_noise;
`endif

    if (fell_asleep) begin
      // Falling asleep overrides everything, including same-cycle events.
      w_state_next     = ST_IDLE;
      w_burst_cnt_next = 4'd0;
      w_refr_cnt_next  = 8'd0;
`ifdef MOOD_EVENT_QUEUE_EN
      w_pend_valid_next = 1'b0;
      w_pend_noise_next = 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ev_noise) begin
            w_start_noise = 1'b1;
          end else if (w_ev_pet && !asleep) begin
            w_start_pet = 1'b1;
          end else if (r_decay_cnt == DECAY_LAST) begin
            // Drift each mood one step toward mid-range; pleasure is frozen
            // while asleep.
            if (stress_indicator == 2'd3) begin
              w_stress_dec_next = 1'b1;
            end else if (stress_indicator == 2'd0) begin
              w_stress_inc_next = 1'b1;
            end
            if (!asleep) begin
              if (pleasure_indicator == 2'd3) begin
                w_pleasure_dec_next = 1'b1;
              end else if (pleasure_indicator == 2'd0) begin
                w_pleasure_inc_next = 1'b1;
              end
            end
          end else begin
            w_decay_cnt_next = r_decay_cnt + 8'd1;
          end
        end

        ST_PET_BURST, ST_NOISE_BURST: begin
          // r_burst_cnt counts pulses already registered for this burst.
          if (r_burst_cnt == BURST_LAST) begin
            w_state_next     = ST_REFRACT;
            w_burst_cnt_next = 4'd0;
            w_refr_cnt_next  = 8'd0;
          end else begin
            w_burst_cnt_next = r_burst_cnt + 4'd1;
            if (r_state == ST_PET_BURST) begin
              w_pleasure_inc_next = 1'b1;
              w_stress_dec_next   = 1'b1;
            end else begin
              w_stress_inc_next   = 1'b1;
              w_pleasure_dec_next = ~asleep;
            end
          end
`ifdef MOOD_EVENT_QUEUE_EN
          w_pend_valid_next = w_cap_valid;
          w_pend_noise_next = w_cap_noise;
`endif
        end

        ST_REFRACT: begin
          if (r_refr_cnt == REFR_LAST) begin
            w_state_next    = ST_IDLE;
            w_refr_cnt_next = 8'd0;
`ifdef MOOD_EVENT_QUEUE_EN
            // Serve the pending event now, skipping the IDLE cycle. A pet
            // that finds the creature asleep is discarded here.
            if (w_cap_valid) begin
              if (w_cap_noise) begin
                w_start_noise = 1'b1;
              end else if (!asleep) begin
                w_start_pet = 1'b1;
              end
            end
            w_pend_valid_next = 1'b0;
            w_pend_noise_next = 1'b0;
`endif
          end else begin
            w_refr_cnt_next = r_refr_cnt + 8'd1;
`ifdef MOOD_EVENT_QUEUE_EN
            w_pend_valid_next = w_cap_valid;
            w_pend_noise_next = w_cap_noise;
`endif
          end
        end

        default: begin
          w_state_next = ST_IDLE;
        end
      endcase

      // Accepting an event registers the first burst pulse immediately, so
      // it is visible in the cycle right after the event was sampled.
      if (w_start_noise) begin
        w_state_next        = ST_NOISE_BURST;
        w_burst_cnt_next    = 4'd1;
        w_decay_cnt_next    = 8'd0;
        w_stress_inc_next   = 1'b1;
        w_stress_dec_next   = 1'b0;
        w_pleasure_inc_next = 1'b0;
        w_pleasure_dec_next = ~asleep;
      end else if (w_start_pet) begin
        w_state_next        = ST_PET_BURST;
        w_burst_cnt_next    = 4'd1;
        w_decay_cnt_next    = 8'd0;
        w_stress_inc_next   = 1'b0;
        w_stress_dec_next   = 1'b1;
        w_pleasure_inc_next = 1'b1;
        w_pleasure_dec_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_prev_pet     <= 1'b0;
      r_prev_noise   <= 1'b0;
      r_burst_cnt    <= 4'd0;
      r_refr_cnt     <= 8'd0;
      r_decay_cnt    <= 8'd0;
      r_stress_inc   <= 1'b0;
      r_stress_dec   <= 1'b0;
      r_pleasure_inc <= 1'b0;
      r_pleasure_dec <= 1'b0;
`ifdef MOOD_EVENT_QUEUE_EN
      r_pend_valid   <= 1'b0;
      r_pend_noise   <= 1'b0;
`endif
    end else begin
      r_state        <= w_state_next;
      r_prev_pet     <= stim_pet;
      r_prev_noise   <= stim_noise;
      r_burst_cnt    <= w_burst_cnt_next;
      r_refr_cnt     <= w_refr_cnt_next;
      r_decay_cnt    <= w_decay_cnt_next;
      r_stress_inc   <= w_stress_inc_next;
      r_stress_dec   <= w_stress_dec_next;
      r_pleasure_inc <= w_pleasure_inc_next;
      r_pleasure_dec <= w_pleasure_dec_next;
`ifdef MOOD_EVENT_QUEUE_EN
      r_pend_valid   <= w_pend_valid_next;
      r_pend_noise   <= w_pend_noise_next;
`endif
    end
  end

  assign stress_inc   = r_stress_inc;
  assign stress_dec   = r_stress_dec;
  assign pleasure_inc = r_pleasure_inc;
  assign pleasure_dec = r_pleasure_dec;
  assign busy         = (r_state != ST_IDLE);
  assign state        = r_state;

endmodule

// File: tb/tb_mood_stimulus_controller.sv
// tb/tb_mood_stimulus_controller.sv - directed table-driven bench for mood_stimulus_controller

module tb_mood_stimulus_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       stim_pet;
  logic       stim_noise;
  logic       asleep;
  logic       fell_asleep;
  logic [1:0] stress_indicator;
  logic [1:0] pleasure_indicator;
  logic       stress_inc;
  logic       stress_dec;
  logic       pleasure_inc;
  logic       pleasure_dec;
  logic       busy;
  logic [1:0] state;

  always #5 clk = ~clk;

  mood_stimulus_controller #(
    .BURST_LEN   (4),
    .REFRACTORY  (8),
    .DECAY_PERIOD(16)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stim_pet          (stim_pet),
    .stim_noise        (stim_noise),
    .asleep            (asleep),
    .fell_asleep       (fell_asleep),
    .stress_indicator  (stress_indicator),
    .pleasure_indicator(pleasure_indicator),
    .stress_inc        (stress_inc),
    .stress_dec        (stress_dec),
    .pleasure_inc      (pleasure_inc),
    .pleasure_dec      (pleasure_dec),
    .busy              (busy),
    .state             (state)
  );

  // Expected output codes: {stress_inc, stress_dec, pleasure_inc, pleasure_dec, state[1:0]}
  localparam logic [5:0] E_IDLE      = 6'b0000_00;
  localparam logic [5:0] E_PET       = 6'b0110_01;
  localparam logic [5:0] E_NOISE     = 6'b1001_10;
  localparam logic [5:0] E_NOISE_SLP = 6'b1000_10;
  localparam logic [5:0] E_REF       = 6'b0000_11;
  localparam logic [5:0] E_DRIFT_UP  = 6'b1010_00;
  localparam logic [5:0] E_DRIFT_DN  = 6'b0101_00;
  localparam logic [5:0] E_DRIFT_SLP = 6'b0100_00;

  typedef struct {
    string      name;
    int         rep;
    logic       r;
    logic       p;
    logic       n;
    logic       a;
    logic       f;
    logic [1:0] si;
    logic [1:0] pi;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input string name, input int rep, input logic r, input logic p,
                     input logic n, input logic a, input logic f,
                     input logic [1:0] si, input logic [1:0] pi, input logic [5:0] exp);
    vec_t v;
    v.name = name; v.rep = rep; v.r = r; v.p = p; v.n = n; v.a = a; v.f = f;
    v.si = si; v.pi = pi; v.exp = exp;
    tbl.push_back(v);
  endtask

  // Drive one cycle of inputs, clock, then compare outputs #1 after the edge.
  task automatic cyc(input string name, input logic r, input logic p, input logic n,
                     input logic a, input logic f, input logic [1:0] si,
                     input logic [1:0] pi, input logic [5:0] exp);
    logic [6:0] act;
    logic [6:0] req;
    rst = r; stim_pet = p; stim_noise = n; asleep = a; fell_asleep = f;
    stress_indicator = si; pleasure_indicator = pi;
    @(posedge clk);
    #1;
    act = {stress_inc, stress_dec, pleasure_inc, pleasure_dec, busy, state};
    req = {exp[5:2], (exp[1:0] != 2'd0), exp[1:0]};
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (si sd pi pd busy state)", name, act, req);
    end
  endtask

  initial begin
    rst = 1'b1; stim_pet = 1'b0; stim_noise = 1'b0; asleep = 1'b0; fell_asleep = 1'b0;
    stress_indicator = 2'd1; pleasure_indicator = 2'd2;

    // Reset, then passive drift with several indicator patterns.
    add("reset",          1, 1, 0, 0, 0, 0, 2'd0, 2'd0, E_IDLE);
    add("decay_wait",    15, 0, 0, 0, 0, 0, 2'd0, 2'd0, E_IDLE);
    add("decay_up",       1, 0, 0, 0, 0, 0, 2'd0, 2'd0, E_DRIFT_UP);
    add("decay_wait2",   15, 0, 0, 0, 0, 0, 2'd0, 2'd0, E_IDLE);
    add("decay_down",     1, 0, 0, 0, 0, 0, 2'd3, 2'd3, E_DRIFT_DN);
    add("decay_mid",     16, 0, 0, 0, 0, 0, 2'd1, 2'd1, E_IDLE);
    add("decay_slp_wait",15, 0, 0, 0, 1, 0, 2'd3, 2'd3, E_IDLE);
    add("decay_slp",      1, 0, 0, 0, 1, 0, 2'd3, 2'd3, E_DRIFT_SLP);
    // Pet burst, refractory hold, held level gives no second burst.
    add("pet_burst",      4, 0, 1, 0, 0, 0, 2'd1, 2'd2, E_PET);
    add("pet_refract",    8, 0, 1, 0, 0, 0, 2'd1, 2'd2, E_REF);
    add("pet_hold",       6, 0, 1, 0, 0, 0, 2'd1, 2'd2, E_IDLE);
    add("pet_low",        1, 0, 0, 0, 0, 0, 2'd1, 2'd2, E_IDLE);
    // Simultaneous edges: noise wins, pet dropped.
    add("both_burst",     4, 0, 1, 1, 0, 0, 2'd1, 2'd2, E_NOISE);
    add("both_refract",   8, 0, 1, 1, 0, 0, 2'd1, 2'd2, E_REF);
    add("both_idle",      2, 0, 1, 1, 0, 0, 2'd1, 2'd2, E_IDLE);
    add("both_low",       1, 0, 0, 0, 0, 0, 2'd1, 2'd2, E_IDLE);
    // Asleep: noise spares pleasure, pet is ignored.
    add("slp_noise",      4, 0, 0, 1, 1, 0, 2'd1, 2'd2, E_NOISE_SLP);
    add("slp_refract",    8, 0, 0, 1, 1, 0, 2'd1, 2'd2, E_REF);
    add("slp_idle",       1, 0, 0, 1, 1, 0, 2'd1, 2'd2, E_IDLE);
    add("slp_low",        1, 0, 0, 0, 1, 0, 2'd1, 2'd2, E_IDLE);
    add("slp_pet",        4, 0, 1, 0, 1, 0, 2'd1, 2'd2, E_IDLE);
    add("slp_pet_low",    1, 0, 0, 0, 0, 0, 2'd1, 2'd2, E_IDLE);
    // Event arriving on the decay-expiry cycle wins over the drift pulse.
    add("race_reset",     1, 1, 0, 0, 0, 0, 2'd0, 2'd0, E_IDLE);
    add("race_wait",     15, 0, 0, 0, 0, 0, 2'd0, 2'd0, E_IDLE);
    add("race_pet",       4, 0, 1, 0, 0, 0, 2'd0, 2'd0, E_PET);
    add("race_refract",   8, 0, 1, 0, 0, 0, 2'd0, 2'd0, E_REF);
    add("race_idle",      1, 0, 0, 0, 0, 0, 2'd1, 2'd2, E_IDLE);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].rep; k++) begin
        cyc(tbl[i].name, tbl[i].r, tbl[i].p, tbl[i].n, tbl[i].a, tbl[i].f,
            tbl[i].si, tbl[i].pi, tbl[i].exp);
      end
    end

    // fell_asleep in the 2nd burst cycle: two pulses only, then the decay
    // timer restarts from zero (16 quiet cycles, drift on the 17th).
    cyc("fa_b1",  0, 1, 0, 0, 0, 2'd0, 2'd0, E_PET);
    cyc("fa_b2",  0, 1, 0, 0, 0, 2'd0, 2'd0, E_PET);
    cyc("fa_cut", 0, 1, 0, 0, 1, 2'd0, 2'd0, E_IDLE);
    for (int k = 0; k < 15; k++) cyc("fa_quiet", 0, 1, 0, 0, 0, 2'd0, 2'd0, E_IDLE);
    cyc("fa_drift", 0, 1, 0, 0, 0, 2'd0, 2'd0, E_DRIFT_UP);
    cyc("fa_low",   0, 0, 0, 0, 0, 2'd1, 2'd2, E_IDLE);

    // Reset in the middle of REFRACT.
    for (int k = 0; k < 4; k++) cyc("rr_burst", 0, 1, 0, 0, 0, 2'd1, 2'd2, E_PET);
    for (int k = 0; k < 3; k++) cyc("rr_ref",   0, 0, 0, 0, 0, 2'd1, 2'd2, E_REF);
    cyc("rr_rst", 1, 0, 0, 0, 0, 2'd1, 2'd2, E_IDLE);
    for (int k = 0; k < 2; k++) cyc("rr_after", 0, 0, 0, 0, 0, 2'd1, 2'd2, E_IDLE);

    // Pet edge during REFRACT.
    for (int k = 0; k < 4; k++) cyc("q_burst", 0, 1, 0, 0, 0, 2'd1, 2'd2, E_PET);
    cyc("q_ref0", 0, 0, 0, 0, 0, 2'd1, 2'd2, E_REF);
    for (int k = 0; k < 7; k++) cyc("q_ref_pet", 0, 1, 0, 0, 0, 2'd1, 2'd2, E_REF);
`ifdef MOOD_EVENT_QUEUE_EN
    for (int k = 0; k < 4; k++) cyc("q_served", 0, 1, 0, 0, 0, 2'd1, 2'd2, E_PET);
    for (int k = 0; k < 8; k++) cyc("q_ref2",   0, 1, 0, 0, 0, 2'd1, 2'd2, E_REF);
    cyc("q_idle", 0, 1, 0, 0, 0, 2'd1, 2'd2, E_IDLE);
`else
    for (int k = 0; k < 4; k++) cyc("q_dropped", 0, 1, 0, 0, 0, 2'd1, 2'd2, E_IDLE);
    cyc("q_low", 0, 0, 0, 0, 0, 2'd1, 2'd2, E_IDLE);
    for (int k = 0; k < 4; k++) cyc("q_fresh", 0, 1, 0, 0, 0, 2'd1, 2'd2, E_PET);
    for (int k = 0; k < 8; k++) cyc("q_ref2",  0, 1, 0, 0, 0, 2'd1, 2'd2, E_REF);
    cyc("q_idle", 0, 1, 0, 0, 0, 2'd1, 2'd2, E_IDLE);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
